// File: rtl/cpu_trace_buffer.sv
// Commit-event trace FIFO with sequence tagging and drop tracking.
// Define TRACE_DROP_CNT_EN to enable the saturating drop_cnt counter.
module cpu_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ev_valid,
  input  logic          ev_kind,
  input  logic [31:0]   ev_pc,
  input  logic [31:0]   ev_addr,
  input  logic [31:0]   ev_data,
  input  logic          clear,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_kind,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_addr,
  output logic [31:0]   out_data,
  output logic [15:0]   out_seq,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic [15:0]   drop_cnt
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic          mem_kind [DEPTH];
  logic [31:0]   mem_pc   [DEPTH];
  logic [31:0]   mem_addr [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [15:0]   mem_seq  [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   lvl;
  logic [15:0]   seq;
  logic          ovf;

  logic          eligible;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic [31:0]   st_addr;

  // writes to x0 never reach the trace
  assign eligible = ev_valid &
                    ~(~ev_kind & (ev_addr[4:0] == 5'd0));
  assign full     = (lvl == FULL_LVL);
  assign pop      = out_valid & out_ready;
  assign push     = eligible & (~full | pop);
  assign drop     = eligible & full & ~pop;
  assign st_addr  = ev_kind ? ev_addr
                            : {27'd0, ev_addr[4:0]};

  assign out_valid = (lvl != '0);
  assign out_kind  = mem_kind[rd_ptr];
  assign out_pc    = mem_pc[rd_ptr];
  assign out_addr  = mem_addr[rd_ptr];
  assign out_data  = mem_data[rd_ptr];
  assign out_seq   = mem_seq[rd_ptr];
  assign level     = lvl;
  assign overflow  = ovf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      lvl    <= '0;
      seq    <= '0;
      ovf    <= 1'b0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      lvl    <= '0;
      seq    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        seq    <= seq + 16'd1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        lvl <= lvl + 1'b1;
      else if (pop && !push)
        lvl <= lvl - 1'b1;
      if (drop)
        ovf <= 1'b1;
    end
  end

  // payload storage needs no reset; out_* are ignored while empty
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem_kind[wr_ptr] <= ev_kind;
      mem_pc[wr_ptr]   <= ev_pc;
      mem_addr[wr_ptr] <= st_addr;
      mem_data[wr_ptr] <= ev_data;
      mem_seq[wr_ptr]  <= seq;
    end
  end

`ifdef TRACE_DROP_CNT_EN
  logic [15:0] dcnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      dcnt <= '0;
    else if (clear)
      dcnt <= '0;
    else if (drop && dcnt != 16'hFFFF)
      dcnt <= dcnt + 16'd1;
  end

  assign drop_cnt = dcnt;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed self-checking bench for cpu_trace_buffer.
// Each task drives one scenario and checks inline.
module tb_cpu_trace_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        ev_valid;
  logic        ev_kind;
  logic [31:0] ev_pc;
  logic [31:0] ev_addr;
  logic [31:0] ev_data;
  logic        clear;
  logic        out_valid;
  logic        out_ready;
  logic        out_kind;
  logic [31:0] out_pc;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic [15:0] out_seq;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] drop_cnt;

  int passed = 0;
  int total  = 0;

`ifdef TRACE_DROP_CNT_EN
  localparam logic [15:0] EXP_DROP = 16'd1;
`else
  localparam logic [15:0] EXP_DROP = 16'd0;
`endif

  cpu_trace_buffer #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .reset(reset),
    .ev_valid(ev_valid), .ev_kind(ev_kind),
    .ev_pc(ev_pc), .ev_addr(ev_addr),
    .ev_data(ev_data), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_kind(out_kind), .out_pc(out_pc),
    .out_addr(out_addr), .out_data(out_data),
    .out_seq(out_seq), .level(level),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ev(input logic k, input logic [31:0] pc,
                        input logic [31:0] a, input logic [31:0] d);
    ev_valid = 1'b1;
    ev_kind  = k;
    ev_pc    = pc;
    ev_addr  = a;
    ev_data  = d;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; ev_valid = 1'b0; ev_kind = 1'b0;
    ev_pc = '0; ev_addr = '0; ev_data = '0;
    clear = 1'b0; out_ready = 1'b0;
    tick(); tick();
    total++;
    if (level !== 5'd0) $display("FAIL reset_level got %0d exp 0", level);
    else passed++;
    total++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", out_valid);
    else passed++;
    total++;
    if (overflow !== 1'b0) $display("FAIL reset_ovf got %b exp 0", overflow);
    else passed++;
    total++;
    if (drop_cnt !== 16'd0) $display("FAIL reset_drop got %0d exp 0", drop_cnt);
    else passed++;
    reset = 1'b1;
  endtask

  task automatic test_zero_reg();
    set_ev(1'b0, 32'h2000, 32'h0000_0020, 32'hDEAD_BEEF);
    tick();
    ev_valid = 1'b0;
    total++;
    if (level !== 5'd0) $display("FAIL x0_level got %0d exp 0", level);
    else passed++;
    total++;
    if (overflow !== 1'b0) $display("FAIL x0_ovf got %b exp 0", overflow);
    else passed++;
  endtask

  task automatic test_first_event();
    out_ready = 1'b0;
    set_ev(1'b0, 32'h3000, 32'd5, 32'h1234_5678);
    tick();
    ev_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1) $display("FAIL first_valid got %b exp 1", out_valid);
    else passed++;
    total++;
    if (out_addr !== 32'd5) $display("FAIL first_addr got %h exp 5", out_addr);
    else passed++;
    total++;
    if (out_data !== 32'h1234_5678) $display("FAIL first_data got %h exp 12345678", out_data);
    else passed++;
    total++;
    if (out_seq !== 16'd0) $display("FAIL first_seq got %0d exp 0", out_seq);
    else passed++;
    total++;
    if (level !== 5'd1) $display("FAIL first_level got %0d exp 1", level);
    else passed++;
    total++;
    if (out_pc !== 32'h3000 || out_kind !== 1'b0)
      $display("FAIL first_pc_kind got %h/%b exp 3000/0", out_pc, out_kind);
    else passed++;
    set_ev(1'b0, 32'h3004, 32'hFFFF_FFE5, 32'hCAFE_F00D);
    tick();
    set_ev(1'b1, 32'h3008, 32'hFFFF_FFE0, 32'h0BAD_BEEF);
    tick();
    ev_valid = 1'b0;
    total++;
    if (level !== 5'd3) $display("FAIL three_level got %0d exp 3", level);
    else passed++;
    total++;
    if (out_data !== 32'h1234_5678) $display("FAIL hold_data got %h exp 12345678", out_data);
    else passed++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (out_seq !== 16'd1 || out_addr !== 32'd5 || out_pc !== 32'h3004)
      $display("FAIL grf_mask got seq %0d addr %h pc %h exp 1/5/3004",
               out_seq, out_addr, out_pc);
    else passed++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (out_seq !== 16'd2 || out_kind !== 1'b1 || out_addr !== 32'hFFFF_FFE0)
      $display("FAIL dm_addr got seq %0d kind %b addr %h exp 2/1/ffffffe0",
               out_seq, out_kind, out_addr);
    else passed++;
    out_ready = 1'b1;
    tick();
    total++;
    if (level !== 5'd0 || out_valid !== 1'b0)
      $display("FAIL drain_empty got lvl %0d v %b exp 0/0", level, out_valid);
    else passed++;
    tick();
    out_ready = 1'b0;
    total++;
    if (level !== 5'd0) $display("FAIL empty_pop got %0d exp 0", level);
    else passed++;
  endtask

  task automatic test_overflow();
    do_clear();
    for (int i = 0; i < 17; i++) begin
      set_ev(1'b1, 32'h4000 + 32'(4*i), 32'h100 + 32'(i), 32'(i));
      tick();
    end
    ev_valid = 1'b0;
    total++;
    if (level !== 5'd16) $display("FAIL ovf_level got %0d exp 16", level);
    else passed++;
    total++;
    if (overflow !== 1'b1) $display("FAIL ovf_flag got %b exp 1", overflow);
    else passed++;
    total++;
    if (drop_cnt !== EXP_DROP) $display("FAIL ovf_drop got %0d exp %0d", drop_cnt, EXP_DROP);
    else passed++;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (out_seq !== 16'(i) || out_data !== 32'(i))
        $display("FAIL ovf_drain%0d got seq %0d data %0d exp %0d",
                 i, out_seq, out_data, i);
      else passed++;
      tick();
    end
    out_ready = 1'b0;
    total++;
    if (level !== 5'd0 || overflow !== 1'b1)
      $display("FAIL ovf_after got lvl %0d ovf %b exp 0/1", level, overflow);
    else passed++;
  endtask

  task automatic test_full_pushpop();
    do_clear();
    total++;
    if (overflow !== 1'b0 || drop_cnt !== 16'd0)
      $display("FAIL clr_flags got ovf %b drop %0d exp 0/0", overflow, drop_cnt);
    else passed++;
    for (int i = 0; i < 16; i++) begin
      set_ev(1'b1, 32'h5000, 32'h200, 32'h100 + 32'(i));
      tick();
    end
    ev_valid = 1'b0;
    total++;
    if (level !== 5'd16 || overflow !== 1'b0)
      $display("FAIL full_state got lvl %0d ovf %b exp 16/0", level, overflow);
    else passed++;
    set_ev(1'b1, 32'h5004, 32'h204, 32'hAAAA_5555);
    out_ready = 1'b1;
    tick();
    ev_valid = 1'b0;
    total++;
    if (level !== 5'd16 || overflow !== 1'b0)
      $display("FAIL full_pp got lvl %0d ovf %b exp 16/0", level, overflow);
    else passed++;
    for (int i = 0; i < 15; i++) tick();
    out_ready = 1'b0;
    total++;
    if (out_seq !== 16'd16 || out_data !== 32'hAAAA_5555 || level !== 5'd1)
      $display("FAIL full_new got seq %0d data %h lvl %0d exp 16/aaaa5555/1",
               out_seq, out_data, level);
    else passed++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    do_clear();
    for (int i = 0; i < 7; i++) begin
      set_ev(1'b0, 32'h6000, 32'd1 + 32'(i), 32'(i));
      tick();
    end
    ev_valid = 1'b0;
    total++;
    if (level !== 5'd7) $display("FAIL ar_pre got %0d exp 7", level);
    else passed++;
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (level !== 5'd0 || out_valid !== 1'b0)
      $display("FAIL ar_async got lvl %0d v %b exp 0/0", level, out_valid);
    else passed++;
    #2;
    reset = 1'b1;
    set_ev(1'b0, 32'h6100, 32'd9, 32'h0000_0099);
    tick();
    ev_valid = 1'b0;
    total++;
    if (level !== 5'd1 || out_seq !== 16'd0 || out_data !== 32'h99)
      $display("FAIL ar_first got lvl %0d seq %0d data %h exp 1/0/99",
               level, out_seq, out_data);
    else passed++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_clear();
    for (int i = 0; i < 3; i++) begin
      set_ev(1'b1, 32'h7000, 32'h300, 32'(i));
      tick();
    end
    ev_valid = 1'b0;
    total++;
    if (level !== 5'd3) $display("FAIL clr_pre got %0d exp 3", level);
    else passed++;
    set_ev(1'b1, 32'h7004, 32'h304, 32'h77);
    out_ready = 1'b1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    ev_valid = 1'b0;
    out_ready = 1'b0;
    total++;
    if (level !== 5'd0 || out_valid !== 1'b0 || overflow !== 1'b0)
      $display("FAIL clr_prio got lvl %0d v %b ovf %b exp 0/0/0",
               level, out_valid, overflow);
    else passed++;
    set_ev(1'b1, 32'h7008, 32'h308, 32'h88);
    tick();
    ev_valid = 1'b0;
    total++;
    if (out_seq !== 16'd0 || level !== 5'd1)
      $display("FAIL clr_seq got seq %0d lvl %0d exp 0/1", out_seq, level);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_zero_reg();
    test_first_event();
    test_overflow();
    test_full_pushpop();
    test_async_reset();
    test_clear();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
